prince_ctr_sched: RTL and testbench

PRINCE_CTR_SCHED -- requirements
Module: prince_ctr_sched

---
 rtl/prince_ctr_sched.sv | 240 ++++++++++++++++++++++++
 tb/tb_prince_ctr_sched.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prince_ctr_sched.sv
// -----------------------------------------------------------------------------
// prince_ctr_sched
//
// Counter-mode job scheduler for a fixed-latency block cipher core.
// A job is started with an initial counter block (iv) and a length in
// blocks. The scheduler presents iv, iv+1, ... to the core. It tracks the
// in-flight blocks with a valid shift register and captures each result
// into a keystream FIFO. Issue is credit-limited, so the FIFO can never
// overflow.
//
// Ports
//   clk         : single clock, rising edge
//   sys_rst     : asynchronous active-high reset
//   start       : one-cycle job request, honoured only in IDLE
//   abort       : terminate the current job (RUN/DRAIN -> IDLE, no done)
//   iv          : initial counter block, sampled with start
//   num_blocks  : job length in blocks, sampled with start (0 = ignored)
//   core_en     : core enable, high while a job is active
//   core_ctr    : counter block presented to the core
//   core_ct     : core result, CIPHER_LATENCY cycles after issue
//   ks_data     : keystream block at the FIFO head
//   ks_valid    : ks_data is valid
//   ks_ready    : consumer accepts ks_data
//   busy        : high in every state except IDLE
//   done        : one-cycle pulse on normal job completion
// -----------------------------------------------------------------------------
module prince_ctr_sched #(
  parameter int CIPHER_WIDTH   = 64,
  parameter int CIPHER_LATENCY = 5,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                    clk,
  input  logic                    sys_rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CIPHER_WIDTH-1:0] iv,
  input  logic [15:0]             num_blocks,
  output logic                    core_en,
  output logic [CIPHER_WIDTH-1:0] core_ctr,
  input  logic [CIPHER_WIDTH-1:0] core_ct,
  output logic [CIPHER_WIDTH-1:0] ks_data,
  output logic                    ks_valid,
  input  logic                    ks_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Number of set bits in the valid shift register (blocks inside the core).
  function automatic logic [15:0] popcount(input logic [CIPHER_LATENCY-1:0] v);
    logic [15:0] c;
    c = 16'd0;
    for (int i = 0; i < CIPHER_LATENCY; i++) begin
      c = c + {15'd0, v[i]};
    end
    return c;
  endfunction

  state_e                    state_q, state_d;
  logic [CIPHER_WIDTH-1:0]   ctr_q, ctr_d;
  logic [15:0]               remaining_q, remaining_d;
  logic [CIPHER_WIDTH-1:0]   core_ctr_q, core_ctr_d;
  logic [CIPHER_LATENCY-1:0] vld_q, vld_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      ks_valid_q, ks_valid_d;
  logic                      busy_q, busy_d;
  logic                      core_en_q, core_en_d;
  logic                      done_q, done_d;
  logic [CIPHER_WIDTH-1:0]   mem_q [FIFO_DEPTH];

  logic        issue_s;
  logic        clear_s;
  logic        wr_s;
  logic        pop_s;
  logic [15:0] inflight_s;
  logic [15:0] occ_s;

  // Next-state logic: job FSM, counter issue, valid pipeline and FIFO bookkeeping.
  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    remaining_d = remaining_q;
    core_ctr_d  = core_ctr_q;
    issue_s     = 1'b0;
    clear_s     = 1'b0;
    done_d      = 1'b0;
    vld_d       = vld_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    inflight_s = popcount(vld_q);
    // Credit: blocks inside the core plus blocks already buffered.
    occ_s      = inflight_s + 16'(count_q);

    case (state_q)
      ST_IDLE: begin
        // abort outranks start; a zero-length request is ignored.
        if (start && !abort && (num_blocks != 16'd0)) begin
          state_d     = ST_RUN;
          ctr_d       = iv;
          remaining_d = num_blocks;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          clear_s = 1'b1;
        end else if (remaining_q == 16'd0) begin
          state_d = ST_DRAIN;
        end else if (occ_s < 16'(FIFO_DEPTH)) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
          clear_s = 1'b1;
        end else if ((inflight_s == 16'd0) && (count_q == '0)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        clear_s = 1'b1;
      end
    endcase

    if (issue_s) begin
      core_ctr_d  = ctr_q;
      ctr_d       = ctr_q + CIPHER_WIDTH'(1'b1);
      remaining_d = remaining_q - 16'd1;
    end else begin
      core_ctr_d = core_ctr_q;
    end

    // The oldest stage marks the cycle in which core_ct carries its result.
    wr_s  = vld_q[CIPHER_LATENCY-1] && !clear_s;
    pop_s = ks_valid_q && ks_ready && !clear_s;

    vld_d[0] = issue_s;
    for (int i = 1; i < CIPHER_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    if (clear_s) begin
      vld_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_s, pop_s})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
    end

    ks_valid_d = (count_d != '0);
    busy_d     = (state_d != ST_IDLE);
    core_en_d  = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      ctr_q       <= '0;
      remaining_q <= 16'd0;
      core_ctr_q  <= '0;
      vld_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ks_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      core_en_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      remaining_q <= remaining_d;
      core_ctr_q  <= core_ctr_d;
      vld_q       <= vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ks_valid_q  <= ks_valid_d;
      busy_q      <= busy_d;
      core_en_q   <= core_en_d;
      done_q      <= done_d;
    end
  end

  // Keystream storage; cleared on reset so ks_data reads zero afterwards.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_s) begin
      mem_q[wr_ptr_q] <= core_ct;
    end
  end

  assign core_en  = core_en_q;
  assign core_ctr = core_ctr_q;
  assign ks_data  = mem_q[rd_ptr_q];
  assign ks_valid = ks_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_prince_ctr_sched.sv
// -----------------------------------------------------------------------------
// tb_prince_ctr_sched
//
// Directed bench for prince_ctr_sched. A behavioural cipher core with a
// fixed latency produces E(x) for each counter block. A table of jobs is
// run with the consumer always ready. Hand-written sequences cover
// back-pressure, abort, reset in DRAIN and ignored starts.
// -----------------------------------------------------------------------------
module tb_prince_ctr_sched;

  localparam int W = 64;
  localparam int L = 5;
  localparam int D = 8;

  logic          clk;
  logic          sys_rst;
  logic          start;
  logic          abort;
  logic [W-1:0]  iv;
  logic [15:0]   num_blocks;
  logic          core_en;
  logic [W-1:0]  core_ctr;
  logic [W-1:0]  core_ct;
  logic [W-1:0]  ks_data;
  logic          ks_valid;
  logic          ks_ready;
  logic          busy;
  logic          done;

  int n_vec;
  int n_err;

  prince_ctr_sched #(
    .CIPHER_WIDTH  (W),
    .CIPHER_LATENCY(L),
    .FIFO_DEPTH    (D)
  ) dut (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .abort     (abort),
    .iv        (iv),
    .num_blocks(num_blocks),
    .core_en   (core_en),
    .core_ctr  (core_ctr),
    .core_ct   (core_ct),
    .ks_data   (ks_data),
    .ks_valid  (ks_valid),
    .ks_ready  (ks_ready),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in cipher: swap halves and xor a constant (a bijection).
  function automatic logic [W-1:0] enc(input logic [W-1:0] x);
    return {x[31:0], x[63:32]} ^ 64'h9E37_79B9_7F4A_7C15;
  endfunction

  // Core model: register fed from core_ctr, result L cycles after issue.
  logic [W-1:0] pipe [L-1];
  always @(posedge clk) begin
    pipe[0] <= enc(core_ctr);
    for (int k = 1; k < L - 1; k++) pipe[k] <= pipe[k-1];
  end
  assign core_ct = pipe[L-2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] iv;
    logic [15:0]  nb;
    bit           restart;    // pulse a second start while busy
    int           exp_first;  // cycle of first ks_valid (start cycle = 0)
    int           exp_done;   // cycle of the done pulse
  } job_t;

  // Runs one job with ks_ready held high and checks counters, data and timing.
  task automatic run_job(input job_t j);
    int first_c;
    int done_c;
    int pops;
    int dones;
    first_c = -1;
    done_c  = -1;
    pops    = 0;
    dones   = 0;
    ks_ready   = 1'b1;
    iv         = j.iv;
    num_blocks = j.nb;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (j.restart && c == 2) begin
        start      = 1'b1;
        iv         = 64'h0000_0000_0000_0900;
        num_blocks = 16'd5;
      end else begin
        start = 1'b0;
      end
      if (c >= 2 && c <= int'(j.nb) + 1) chk("core_ctr", core_ctr, j.iv + 64'(c - 2));
      if (ks_valid && first_c < 0) first_c = c;
      if (ks_valid && ks_ready) begin
        chk("ks_data", ks_data, enc(j.iv + 64'(pops)));
        pops++;
      end
      if (done) begin
        dones++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c >= done_c + 2) break;
      step();
    end
    start = 1'b0;
    chk("first_valid_cycle", 64'(first_c), 64'(j.exp_first));
    chk("done_cycle", 64'(done_c), 64'(j.exp_done));
    chk("block_count", 64'(pops), 64'(j.nb));
    chk("done_pulses", 64'(dones), 64'd1);
    chk("busy_after_job", 64'(busy), 64'd0);
  endtask

  job_t jobs [5];

  initial begin
    int issues;
    int pops;
    int dones;
    bit done_seen;
    logic [W-1:0] prev;

    n_vec = 0;
    n_err = 0;
    jobs[0] = '{64'h0000_0000_0000_0000, 16'd3,  1'b0, 7, 11};
    jobs[1] = '{64'h1234_5678_9ABC_DEF0, 16'd1,  1'b0, 7, 9};
    jobs[2] = '{64'hFFFF_FFFF_FFFF_FFFE, 16'd4,  1'b0, 7, 12};
    jobs[3] = '{64'h0000_0000_0000_0700, 16'd2,  1'b1, 7, 10};
    jobs[4] = '{64'h0000_0000_FFFF_FFF0, 16'd16, 1'b0, 7, 24};

    sys_rst    = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    iv         = '0;
    num_blocks = 16'd0;
    ks_ready   = 1'b1;
    repeat (2) step();

    // Reset state.
    chk("rst_core_en", 64'(core_en), 64'd0);
    chk("rst_core_ctr", core_ctr, 64'd0);
    chk("rst_ks_valid", 64'(ks_valid), 64'd0);
    chk("rst_ks_data", ks_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    sys_rst = 1'b0;
    repeat (2) step();

    // Job table.
    for (int n = 0; n < 5; n++) begin
      run_job(jobs[n]);
      step();
    end

    // Back-pressure: 20 blocks, consumer stalled -> exactly D issues.
    ks_ready   = 1'b0;
    iv         = 64'h0000_0000_0000_0500;
    num_blocks = 16'd20;
    start      = 1'b1;
    step();
    start  = 1'b0;
    issues = 0;
    prev   = core_ctr;
    for (int c = 1; c <= 40; c++) begin
      if (core_ctr !== prev) issues++;
      prev = core_ctr;
      step();
    end
    chk("stall_issues", 64'(issues), 64'(D));
    chk("stall_core_ctr", core_ctr, 64'h0000_0000_0000_0507);
    chk("stall_ks_valid", 64'(ks_valid), 64'd1);
    chk("stall_ks_data", ks_data, enc(64'h0000_0000_0000_0500));
    chk("stall_busy", 64'(busy), 64'd1);
    ks_ready  = 1'b1;
    pops      = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 200 && !done_seen; c++) begin
      if (ks_valid && ks_ready) begin
        chk("stall_ks_data_seq", ks_data, enc(64'h0000_0000_0000_0500 + 64'(pops)));
        pops++;
      end
      if (done) done_seen = 1'b1;
      step();
    end
    chk("stall_block_count", 64'(pops), 64'd20);
    chk("stall_done_seen", 64'(done_seen), 64'd1);
    step();

    // Abort two cycles after the 5th issue of a 10-block job.
    iv         = 64'h0000_0000_0000_0040;
    num_blocks = 16'd10;
    start      = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ks_valid", 64'(ks_valid), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done || ks_valid) dones++;
    end
    chk("abort_quiet", 64'(dones), 64'd0);
    run_job('{64'h0000_0000_0000_0100, 16'd2, 1'b0, 7, 10});
    step();

    // Reset while in DRAIN with three blocks buffered.
    ks_ready   = 1'b0;
    iv         = 64'h0000_0000_0000_2000;
    num_blocks = 16'd3;
    start      = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    chk("drain_ks_valid", 64'(ks_valid), 64'd1);
    chk("drain_busy", 64'(busy), 64'd1);
    sys_rst = 1'b1;
    #1;
    chk("arst_core_en", 64'(core_en), 64'd0);
    chk("arst_core_ctr", core_ctr, 64'd0);
    chk("arst_ks_valid", 64'(ks_valid), 64'd0);
    chk("arst_ks_data", ks_data, 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    step();
    sys_rst  = 1'b0;
    ks_ready = 1'b1;
    repeat (8) step();
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_ks_valid", 64'(ks_valid), 64'd0);

    // A zero-length start is ignored.
    iv         = 64'h0000_0000_0000_0333;
    num_blocks = 16'd0;
    start      = 1'b1;
    step();
    start = 1'b0;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      if (done || busy || core_en) dones++;
      step();
    end
    chk("zero_len_ignored", 64'(dones), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
